// File: rtl/conv5x5_window_ctrl.sv
// Control sequencer for a K x K convolution datapath. It walks one raster
// frame and drives the line-buffer and window-chain enables, the column
// address and the row/column position. It also produces window-valid, plus an
// output-valid/last pair delayed to line up with the arithmetic pipeline.
module conv5x5_window_ctrl #(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int K        = 5,
    parameter int PIPE_LAT = 3,
    parameter int AW       = 5,
    parameter int RW       = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_shift_en,
    output logic          o_lb_wr_en,
    output logic [AW-1:0] o_lb_addr,
    output logic [AW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_win_valid,
    output logic          o_out_valid,
    output logic          o_out_last,
    output logic          o_busy,
    output logic          o_done
);

    // Drain counter only needs to reach PIPE_LAT.
    localparam int DW = $clog2(PIPE_LAT + 2);

    localparam logic [AW-1:0] COL_LAST   = AW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [AW-1:0] COL_WIN    = AW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN    = RW'(K - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] drain_q, drain_d;

    logic          win_valid_q;
    logic          win_last_q;
    logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;
    logic [PIPE_LAT-1:0] lpipe_q, lpipe_d;

    logic accept;
    logic col_last;
    logic row_last;

    assign accept   = i_valid && (state_q == S_RUN);
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    // Next-state logic: raster counters advance only on accepted pixels;
    // DRAIN holds long enough for the last result to leave the pipeline.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                col_d   = '0;
                row_d   = '0;
                drain_d = '0;
                if (i_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
        end
    end

    // A window is complete once K rows and K columns have been shifted in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            win_valid_q <= accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
            win_last_q  <= accept && col_last && row_last;
        end
    end

    // Free-running delay line matching the arithmetic pipeline; never stalls.
    generate
        for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign vpipe_d[gi] = win_valid_q;
                assign lpipe_d[gi] = win_last_q;
            end else begin : g_tail
                assign vpipe_d[gi] = vpipe_q[gi-1];
                assign lpipe_d[gi] = lpipe_q[gi-1];
            end
        end
    endgenerate

    // Delay-line registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vpipe_q <= '0;
            lpipe_q <= '0;
        end else begin
            vpipe_q <= vpipe_d;
            lpipe_q <= lpipe_d;
        end
    end

    assign o_ready     = (state_q == S_RUN);
    assign o_shift_en  = accept;
    assign o_lb_wr_en  = accept;
    assign o_lb_addr   = col_q;
    assign o_col       = col_q;
    assign o_row       = row_q;
    assign o_win_valid = win_valid_q;
    assign o_out_valid = vpipe_q[PIPE_LAT-1];
    assign o_out_last  = lpipe_q[PIPE_LAT-1];
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);

endmodule
